// File: rtl/pipeline_mem_stage.sv
// Memory-access stage: executes loads/stores against a word-addressed synchronous
// data RAM and registers {wen, w_data, w_addr} for the write-back stage.
module pipeline_mem_stage #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 4,
    parameter int MADDR = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             valid_in,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             wen_in,
    input  logic [DSIZE-1:0] alu_in,
    input  logic [DSIZE-1:0] st_data_in,
    input  logic [ASIZE-1:0] w_addr_in,
    output logic [DSIZE-1:0] w_data_out,
    output logic [ASIZE-1:0] w_addr_out,
    output logic             wen_out,
    output logic             err_out
);

    logic [DSIZE-1:0] mem [0:(2**MADDR)-1];

    logic [DSIZE-1:0] w_data_q, w_data_d;
    logic [ASIZE-1:0] w_addr_q, w_addr_d;
    logic             wen_q, wen_d;
    logic             err_q, err_d;
    logic             load_q, load_d;
    logic [DSIZE-1:0] rd_q;

    logic [MADDR-1:0] ram_addr;
    logic             addr_ok;
    logic             ram_we;
    logic             ram_re;
    logic             we_d;

    generate
        if (DSIZE > MADDR) begin : g_wide
            assign addr_ok  = (alu_in[DSIZE-1:MADDR] == '0);
            assign ram_addr = alu_in[MADDR-1:0];
        end else if (DSIZE == MADDR) begin : g_equal
            assign addr_ok  = 1'b1;
            assign ram_addr = alu_in;
        end else begin : g_narrow
            assign addr_ok  = 1'b1;
            assign ram_addr = {{(MADDR-DSIZE){1'b0}}, alu_in};
        end
    endgenerate

    // Priority: flush > stall > bubble > illegal > range error > store > load > ALU.
    always_comb begin
        w_data_d = w_data_q;
        w_addr_d = w_addr_q;
        wen_d    = wen_q;
        err_d    = 1'b0;
        load_d   = load_q;
        we_d     = 1'b0;
        if (flush || (!stall && !valid_in)) begin
            w_data_d = '0;
            w_addr_d = '0;
            wen_d    = 1'b0;
            load_d   = 1'b0;
        end else if (stall) begin
            err_d = 1'b0;
        end else if ((mem_read && mem_write) || ((mem_read || mem_write) && !addr_ok)) begin
            w_data_d = '0;
            w_addr_d = '0;
            wen_d    = 1'b0;
            load_d   = 1'b0;
            err_d    = 1'b1;
        end else if (mem_write) begin
            w_data_d = '0;
            w_addr_d = '0;
            wen_d    = 1'b0;
            load_d   = 1'b0;
            we_d     = 1'b1;
        end else if (mem_read) begin
            w_data_d = '0;
            w_addr_d = w_addr_in;
            wen_d    = wen_in;
            load_d   = 1'b1;
        end else begin
            w_data_d = alu_in;
            w_addr_d = w_addr_in;
            wen_d    = wen_in;
            load_d   = 1'b0;
        end
    end

    // The RAM read only happens on an accepted load, so rd_q holds across stalls.
    assign ram_we = we_d & ~rst;
    assign ram_re = load_d & ~load_q & ~rst | (load_d & ~stall & ~flush & valid_in & ~rst);

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= st_data_in;
        if (ram_re) rd_q <= mem[ram_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_data_q <= '0;
            w_addr_q <= '0;
            wen_q    <= 1'b0;
            err_q    <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            w_data_q <= w_data_d;
            w_addr_q <= w_addr_d;
            wen_q    <= wen_d;
            err_q    <= err_d;
            load_q   <= load_d;
        end
    end

    assign w_data_out = load_q ? rd_q : w_data_q;
    assign w_addr_out = w_addr_q;
    assign wen_out    = wen_q;
    assign err_out    = err_q;

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Directed bench for pipeline_mem_stage: each task drives one scenario and checks
// the registered outputs one cycle later against hand-computed values.
module tb_pipeline_mem_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, valid_in, mem_read, mem_write, wen_in;
    logic [15:0] alu_in, st_data_in;
    logic [3:0]  w_addr_in;
    logic [15:0] w_data_out;
    logic [3:0]  w_addr_out;
    logic        wen_out, err_out;

    int vecs = 0;
    int miss = 0;

    always #5 clk = ~clk;

    pipeline_mem_stage #(.DSIZE(16), .ASIZE(4), .MADDR(8)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
        .mem_read(mem_read), .mem_write(mem_write), .wen_in(wen_in),
        .alu_in(alu_in), .st_data_in(st_data_in), .w_addr_in(w_addr_in),
        .w_data_out(w_data_out), .w_addr_out(w_addr_out), .wen_out(wen_out),
        .err_out(err_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr, input logic we,
                         input logic [15:0] a, input logic [15:0] sd, input logic [3:0] wa);
        valid_in = v; mem_read = rd; mem_write = wr; wen_in = we;
        alu_in = a; st_data_in = sd; w_addr_in = wa;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0; idle();
        tick(); tick();
        rst = 1'b0;
        vecs++; if (w_data_out !== 16'h0) begin miss++; $display("FAIL rst_data got %h exp 0000", w_data_out); end
        vecs++; if (w_addr_out !== 4'h0) begin miss++; $display("FAIL rst_addr got %h exp 0", w_addr_out); end
        vecs++; if (wen_out !== 1'b0) begin miss++; $display("FAIL rst_wen got %b exp 0", wen_out); end
        vecs++; if (err_out !== 1'b0) begin miss++; $display("FAIL rst_err got %b exp 0", err_out); end
        // prime 0x10, then reset during a load and during a store
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h1111, 4'h0); tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0, 4'h6); rst = 1'b1; tick();
        vecs++; if (wen_out !== 1'b0 || w_addr_out !== 4'h0 || w_data_out !== 16'h0) begin
            miss++; $display("FAIL rst_mid_load got wen=%b addr=%h data=%h exp 0/0/0000", wen_out, w_addr_out, w_data_out); end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h2222, 4'h0); tick();
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0, 4'h6); tick();
        vecs++; if (w_data_out !== 16'h1111 || wen_out !== 1'b1 || w_addr_out !== 4'h6) begin
            miss++; $display("FAIL rst_no_write got data=%h wen=%b addr=%h exp 1111/1/6", w_data_out, wen_out, w_addr_out); end
        idle(); tick();
    endtask

    task automatic test_alu();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h0, 4'd5); tick();
        vecs++; if (wen_out !== 1'b1 || w_addr_out !== 4'd5 || w_data_out !== 16'h1234) begin
            miss++; $display("FAIL alu_op got wen=%b addr=%h data=%h exp 1/5/1234", wen_out, w_addr_out, w_data_out); end
        vecs++; if (err_out !== 1'b0) begin miss++; $display("FAIL alu_err got %b exp 0", err_out); end
        idle(); tick();
        vecs++; if (wen_out !== 1'b0 || w_addr_out !== 4'h0 || w_data_out !== 16'h0) begin
            miss++; $display("FAIL bubble got wen=%b addr=%h data=%h exp 0/0/0000", wen_out, w_addr_out, w_data_out); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h002A, 16'hBEEF, 4'd9); tick();
        vecs++; if (wen_out !== 1'b0 || w_addr_out !== 4'h0 || w_data_out !== 16'h0) begin
            miss++; $display("FAIL store_out got wen=%b addr=%h data=%h exp 0/0/0000", wen_out, w_addr_out, w_data_out); end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h002A, 16'h0, 4'd3); tick();
        vecs++; if (wen_out !== 1'b1 || w_addr_out !== 4'd3 || w_data_out !== 16'hBEEF) begin
            miss++; $display("FAIL st_ld_fwd got wen=%b addr=%h data=%h exp 1/3/beef", wen_out, w_addr_out, w_data_out); end
        idle(); tick();
    endtask

    task automatic test_range();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h5555, 4'h0); tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0100, 16'h0, 4'd2); tick();
        vecs++; if (err_out !== 1'b1 || wen_out !== 1'b0 || w_data_out !== 16'h0) begin
            miss++; $display("FAIL ld_range got err=%b wen=%b data=%h exp 1/0/0000", err_out, wen_out, w_data_out); end
        idle(); tick();
        vecs++; if (err_out !== 1'b0) begin miss++; $display("FAIL err_pulse got %b exp 0", err_out); end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0100, 16'hAAAA, 4'h0); tick();
        vecs++; if (err_out !== 1'b1 || wen_out !== 1'b0) begin
            miss++; $display("FAIL st_range got err=%b wen=%b exp 1/0", err_out, wen_out); end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0, 4'd1); tick();
        vecs++; if (w_data_out !== 16'h5555 || err_out !== 1'b0) begin
            miss++; $display("FAIL st_range_ram got data=%h err=%b exp 5555/0", w_data_out, err_out); end
        idle(); tick();
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0030, 16'h0001, 4'h0); tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h00C3, 16'h0, 4'd7); tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0030, 16'h7777, 4'h0); stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vecs++; if (wen_out !== 1'b1 || w_addr_out !== 4'd7 || w_data_out !== 16'h00C3 || err_out !== 1'b0) begin
                miss++; $display("FAIL stall_hold[%0d] got wen=%b addr=%h data=%h err=%b exp 1/7/00c3/0", i, wen_out, w_addr_out, w_data_out, err_out); end
        end
        flush = 1'b1; tick();
        flush = 1'b0; stall = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0030, 16'h0, 4'd4); tick();
        vecs++; if (w_data_out !== 16'h0001 || w_addr_out !== 4'd4) begin
            miss++; $display("FAIL stall_no_write got data=%h addr=%h exp 0001/4", w_data_out, w_addr_out); end
        // load held under stall must keep its data, then a stalled store completes on release
        stall = 1'b1; drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0030, 16'h7777, 4'h0); tick();
        vecs++; if (w_data_out !== 16'h0001 || wen_out !== 1'b1) begin
            miss++; $display("FAIL stall_load_hold got data=%h wen=%b exp 0001/1", w_data_out, wen_out); end
        stall = 1'b0; tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0030, 16'h0, 4'd4); tick();
        vecs++; if (w_data_out !== 16'h7777) begin
            miss++; $display("FAIL stall_release got %h exp 7777", w_data_out); end
        idle(); tick();
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0A0A, 4'h0); tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h5A5A, 16'h0, 4'd8); tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h4040, 4'h0); stall = 1'b1; flush = 1'b1; tick();
        stall = 1'b0; flush = 1'b0;
        vecs++; if (wen_out !== 1'b0 || err_out !== 1'b0 || w_data_out !== 16'h0) begin
            miss++; $display("FAIL flush got wen=%b err=%b data=%h exp 0/0/0000", wen_out, err_out, w_data_out); end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0040, 16'h0, 4'd2); tick();
        vecs++; if (w_data_out !== 16'h0A0A) begin
            miss++; $display("FAIL flush_no_write got %h exp 0a0a", w_data_out); end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0040, 16'hFFFF, 4'd2); tick();
        vecs++; if (err_out !== 1'b1 || wen_out !== 1'b0) begin
            miss++; $display("FAIL illegal got err=%b wen=%b exp 1/0", err_out, wen_out); end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0040, 16'h0, 4'd2); tick();
        vecs++; if (err_out !== 1'b0 || w_data_out !== 16'h0A0A) begin
            miss++; $display("FAIL illegal_no_write got err=%b data=%h exp 0/0a0a", err_out, w_data_out); end
        idle(); tick();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_range();
        test_stall();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
